lsu_unit: RTL and testbench
===========================

Name: lsu_unit

Overview:
Load/store unit for the RV32I core.
- Consumes the rs1/rs2 operands read from the register file and computes the effective address rs1+imm.
- Runs a single-outstanding request/ready transaction on the data-memory bus, formatting store byte lanes or aligning and extending load data.
- Drives the register-file write port (write enable, destination index, write data) with the load result.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
MEM_TIMEOUT, 255, maximum cycles in REQ without mem_ready before the transaction aborts with bus_err; 0 disables the watchdog.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
start  in  1  one-cycle launch strobe, sampled only in IDLE
is_store  in  1  1 = store, 0 = load; sampled with start
funct3  in  3  RV32I width/sign code; sampled with start
rs1  in  32  base address operand from register file
rs2  in  32  store data operand from register file
imm  in  32  sign-extended offset
rd  in  5  load destination register index
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
misaligned  out  1  valid with done; address not naturally aligned
illegal  out  1  valid with done; unsupported funct3
bus_err  out  1  valid with done; watchdog expired
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  1 = write
mem_addr  out  32  word-aligned address {ea[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wmask  out  4  byte write strobes; 0000 for loads
mem_ready  in  1  memory accepts/returns in this cycle
mem_rdata  in  32  read data, valid when mem_ready=1
wb_en  out  1  register-file write enable
wb_rd  out  5  register-file write index
wb_data  out  32  register-file write data

Behaviour:
- Reset (rst=0, asynchronous): state IDLE and all outputs 0 immediately, including any mem_req in flight. A transaction in progress is dropped with no done pulse. All outputs are registered.
- States: IDLE, REQ, DONE, FAULT.
- IDLE, start=1: ea = rs1+imm mod 2^32. Latch is_store, funct3, rd, rs2 and ea. Next state is chosen in this priority order:
  - illegal funct3 (load: 3, 6, 7; store: 3 to 7) -> FAULT with illegal=1;
  - misaligned (half with ea[0]=1; word with ea[1:0]!=0) -> FAULT with misaligned=1;
  - otherwise -> REQ.
- IDLE, start=0: stay in IDLE.
- start while busy=1: ignored.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_wdata and mem_wmask are stable until mem_ready=1.
  - mem_ready=1 -> DONE. For loads, mem_rdata is captured and formatted in that cycle.
  - Watchdog counter: cleared on entry to REQ. When it reaches MEM_TIMEOUT without mem_ready -> FAULT with bus_err=1; mem_req deasserts.
- DONE: done=1 for one cycle, then IDLE. For a load with rd!=0: wb_en=1, wb_rd=rd, wb_data=result. Loads to x0 and all stores: wb_en=0.
- FAULT: done=1 with exactly one error flag set. No writeback. Next state IDLE.
- Error flags and wb_* are 0 whenever done=0.
- Latency: start in cycle 0 -> mem_req in cycle 1. mem_ready in cycle k -> done in cycle k+1 (minimum 2). Faults: done in cycle 1, no mem_req.
- Store formatting, with lane = ea[1:0]:
  - SB (0): wdata = {4{rs2[7:0]}}, wmask = 0001<<lane.
  - SH (1): wdata = {2{rs2[15:0]}}, wmask = 0011<<lane.
  - SW (2): wdata = rs2, wmask = 1111.
- Load formatting: select the byte or half at lane from mem_rdata.
  - LB (0), LH (1): sign-extend.
  - LBU (4), LHU (5): zero-extend.
  - LW (2): pass through.
- Address wrap: 0xFFFFFFFF+1 = 0x00000000. No overflow fault.

Decomposition:
- rv32i_pkg holds the funct3 localparams (LB/LH/LW/LBU/LHU, SB/SH/SW), the lsu state encoding and XLEN.
- One combinational sub-module, lsu_align, contains store lane replication and mask generation, load extraction and extension, and illegal/misaligned detection.
- lsu_unit holds the FSM, the operand latches, the watchdog counter and the output registers.

Test Plan:
- SW: rs1=0x100, imm=4, rs2=0xDEADBEEF, mem_ready on the 3rd REQ cycle -> mem_addr=0x104, wmask=1111, wdata=0xDEADBEEF; done one cycle after mem_ready; wb_en=0.
- SB/SH lanes: SB with ea=0x103, rs2=0x000000A5 -> wmask=1000, wdata=0xA5A5A5A5. SH with ea=0x102 -> wmask=1100.
- Loads with rdata=0x80F07F01:
  - LB, ea=0x203 -> wb_data=0xFFFFFF80.
  - LBU, ea=0x203 -> 0x00000080.
  - LH, ea=0x200 -> 0x00007F01.
  - LHU, ea=0x202 -> 0x000080F0.
  - LW, rd=5 -> wb_en=1, wb_rd=5, wb_data=0x80F07F01.
  - Load to rd=0 -> wb_en=0.
- Faults:
  - LW with ea=0x202 -> done and misaligned in cycle 1, mem_req never asserted.
  - Load funct3=3 -> illegal=1.
  - Store funct3=4 -> illegal=1.
- Watchdog: MEM_TIMEOUT=4, mem_ready held 0 -> bus_err=1 with done after 4 REQ cycles; mem_req=0 afterwards. start pulsed while busy is ignored.
- Reset mid-REQ: rst=0 asynchronously while mem_req=1 -> mem_req, busy and done go to 0 immediately. After rst=1, a new LW completes normally.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants for the load/store path: datapath width,
// funct3 width/sign codes and the LSU state encoding.
package rv32i_pkg;

  localparam int XLEN = 32;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_REQ   = 2'd1,
    LSU_DONE  = 2'd2,
    LSU_FAULT = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: store byte replication and write
// strobes, load byte/half extraction with sign/zero extension, and the
// illegal-funct3 / misalignment classification.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic [31:0] ldata,
  output logic        illegal,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store data replicated across all lanes; strobes pick the addressed lanes
  always_comb begin
    wdata = '0;
    wmask = '0;
    case (funct3)
      F3_SB: begin
        wdata = {4{rs2[7:0]}};
        wmask = 4'b0001 << lane;
      end
      F3_SH: begin
        wdata = {2{rs2[15:0]}};
        wmask = 4'b0011 << lane;
      end
      F3_SW: begin
        wdata = rs2;
        wmask = 4'b1111;
      end
      default: ;
    endcase
  end

  // Pick the addressed byte/half out of the returned word
  always_comb begin
    byte_sel = '0;
    case (lane)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: ;
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend the selected field according to the load type
  always_comb begin
    ldata = '0;
    case (funct3)
      F3_LB:  ldata = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:  ldata = {{16{half_sel[15]}}, half_sel};
      F3_LW:  ldata = rdata;
      F3_LBU: ldata = {24'd0, byte_sel};
      F3_LHU: ldata = {16'd0, half_sel};
      default: ;
    endcase
  end

  // Classify the request; the FSM gives illegal priority over misaligned
  always_comb begin
    if (is_store) begin
      illegal = (funct3 > F3_SW);
    end else begin
      illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    end
    case (funct3[1:0])
      2'd1:    misaligned = lane[0];
      2'd2:    misaligned = (lane != 2'd0);
      default: misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// RV32I load/store unit: effective-address generation, single-outstanding
// request/ready memory transaction with watchdog, and register-file
// writeback of formatted load data. All outputs are registered.
module lsu_unit #(
  parameter int XLEN        = rv32i_pkg::XLEN,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic            misaligned,
  output logic            illegal,
  output logic            bus_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wmask,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);
  import rv32i_pkg::*;

  localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  lsu_state_e      state_q;
  logic            st_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rs2_q;
  // Only the lane bits of ea are kept; the word address lives in mem_addr_q
  logic [1:0]      lane_q;
  logic [WD_W-1:0] wd_q;

  logic            busy_q, done_q, mis_q, ill_q, berr_q;
  logic            mem_req_q, mem_we_q;
  logic [XLEN-1:0] mem_addr_q, mem_wdata_q;
  logic [3:0]      mem_wmask_q;
  logic            wb_en_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q;

  logic [XLEN-1:0] ea;
  logic            idle;
  logic            al_store;
  logic [2:0]      al_f3;
  logic [1:0]      al_lane;
  logic [XLEN-1:0] al_rs2;
  logic [XLEN-1:0] al_wdata;
  logic [3:0]      al_wmask;
  logic [XLEN-1:0] al_ldata;
  logic            al_illegal;
  logic            al_mis;
  logic            wd_expired;

  assign ea   = rs1 + imm;
  assign idle = (state_q == LSU_IDLE);

  // One align instance serves both phases: live operands while IDLE
  // (classification and store formatting), latched operands while in REQ
  // (load extraction when mem_ready arrives).
  assign al_store = idle ? is_store : st_q;
  assign al_f3    = idle ? funct3   : f3_q;
  assign al_lane  = idle ? ea[1:0]  : lane_q;
  assign al_rs2   = idle ? rs2      : rs2_q;

  lsu_align u_align (
    .is_store   (al_store),
    .funct3     (al_f3),
    .lane       (al_lane),
    .rs2        (al_rs2),
    .rdata      (mem_rdata),
    .wdata      (al_wdata),
    .wmask      (al_wmask),
    .ldata      (al_ldata),
    .illegal    (al_illegal),
    .misaligned (al_mis)
  );

  assign wd_expired = (MEM_TIMEOUT != 0) && (wd_q == WD_W'(MEM_TIMEOUT - 1));

  // FSM, operand latches, watchdog and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LSU_IDLE;
      st_q        <= 1'b0;
      f3_q        <= '0;
      rd_q        <= '0;
      rs2_q       <= '0;
      lane_q      <= '0;
      wd_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      ill_q       <= 1'b0;
      berr_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      wb_en_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      // Completion outputs are single-cycle pulses by default
      done_q    <= 1'b0;
      mis_q     <= 1'b0;
      ill_q     <= 1'b0;
      berr_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;

      case (state_q)
        LSU_IDLE: begin
          if (start) begin
            st_q   <= is_store;
            f3_q   <= funct3;
            rd_q   <= rd;
            rs2_q  <= rs2;
            lane_q <= ea[1:0];
            busy_q <= 1'b1;
            if (al_illegal) begin
              state_q <= LSU_FAULT;
              done_q  <= 1'b1;
              ill_q   <= 1'b1;
            end else if (al_mis) begin
              state_q <= LSU_FAULT;
              done_q  <= 1'b1;
              mis_q   <= 1'b1;
            end else begin
              state_q     <= LSU_REQ;
              wd_q        <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {ea[XLEN-1:2], 2'b00};
              mem_wdata_q <= is_store ? al_wdata : '0;
              mem_wmask_q <= is_store ? al_wmask : '0;
            end
          end
        end

        LSU_REQ: begin
          if (mem_ready || wd_expired) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            done_q      <= 1'b1;
            if (mem_ready) begin
              state_q <= LSU_DONE;
              if (!st_q && (rd_q != 5'd0)) begin
                wb_en_q   <= 1'b1;
                wb_rd_q   <= rd_q;
                wb_data_q <= al_ldata;
              end
            end else begin
              state_q <= LSU_FAULT;
              berr_q  <= 1'b1;
            end
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end

        LSU_DONE, LSU_FAULT: begin
          state_q <= LSU_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= LSU_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign misaligned = mis_q;
  assign illegal    = ill_q;
  assign bus_err    = berr_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wmask  = mem_wmask_q;
  assign wb_en      = wb_en_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed store/load/fault/watchdog/reset
// scenarios plus randomized transactions against a behavioural model.
module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_store;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, imm;
  logic [4:0]  rd;
  logic        busy, done, misaligned, illegal, bus_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  lsu_unit #(.XLEN(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .imm(imm), .rd(rd),
    .busy(busy), .done(done), .misaligned(misaligned), .illegal(illegal),
    .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit ref_legal(input bit st, input logic [2:0] f3);
    if (st) return (f3 <= 3'd2);
    return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int lane,
                                           input logic [31:0] rdata);
    int n;
    logic [31:0] v;
    n = size_of(f3);
    if (n == 4) return rdata;
    v = rdata >> (8 * lane);
    v = v & ((32'd1 << (8 * n)) - 32'd1);
    if (f3 < 3'd4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  function automatic logic [3:0] ref_wmask(input logic [2:0] f3, input int lane);
    int n;
    n = size_of(f3);
    return 4'(((1 << n) - 1) << lane);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (size_of(f3))
      1:       return {24'd0, d[7:0]} * 32'h01010101;
      2:       return {16'd0, d[15:0]} * 32'h00010001;
      default: return d;
    endcase
  endfunction

  task automatic scramble_inputs();
    is_store = 1'($urandom);
    funct3   = 3'($urandom);
    rs1      = $urandom;
    rs2      = $urandom;
    imm      = $urandom;
    rd       = 5'($urandom);
  endtask

  // Drives one transaction from IDLE (entered at posedge+1) and checks it
  // cycle by cycle against the model. Returns observed values for directed tests.
  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] off, input logic [31:0] d, input logic [4:0] r,
                         input int lat, input logic [31:0] rdata, input string tag,
                         output logic [31:0] got_addr, output logic [31:0] got_wdata,
                         output logic [3:0] got_wmask, output logic got_wben,
                         output logic [31:0] got_wb);
    logic [31:0] ea, exp_ld, exp_wd;
    logic [3:0]  exp_wm;
    bit legal, mis, exp_wben;
    int lane;
    ea = a + off;
    lane = int'(ea[1:0]);
    legal = ref_legal(st, f3);
    mis = (ea % size_of(f3)) != 0;
    exp_ld = ref_load(f3, lane, rdata);
    exp_wm = st ? ref_wmask(f3, lane) : 4'b0000;
    exp_wd = ref_wdata(f3, d);
    exp_wben = !st && (r != 5'd0);
    got_addr = '0; got_wdata = '0; got_wmask = '0; got_wben = 1'b0; got_wb = '0;

    start = 1'b1; is_store = st; funct3 = f3; rs1 = a; imm = off; rs2 = d; rd = r;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();

    if (!legal || mis) begin
      total_cnt++;
      if (done !== 1'b1 || illegal !== !legal || misaligned !== (legal && mis) ||
          bus_err !== 1'b0 || mem_req !== 1'b0 || wb_en !== 1'b0 || busy !== 1'b1)
        $display("FAIL %s fault: done=%b ill=%b mis=%b berr=%b req=%b wben=%b busy=%b exp ill=%b mis=%b",
                 tag, done, illegal, misaligned, bus_err, mem_req, wb_en, busy, !legal, legal && mis);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0)
        $display("FAIL %s fault_end: done=%b busy=%b req=%b exp 0/0/0", tag, done, busy, mem_req);
      else pass_cnt++;
    end else begin
      for (int c = 1; c <= lat; c++) begin
        total_cnt++;
        if (mem_req !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || mem_we !== st ||
            mem_addr !== {ea[31:2], 2'b00} || mem_wmask !== exp_wm ||
            (st && mem_wdata !== exp_wd))
          $display("FAIL %s req_c%0d: req=%b done=%b we=%b addr=%h wm=%b wd=%h exp addr=%h wm=%b wd=%h",
                   tag, c, mem_req, done, mem_we, mem_addr, mem_wmask, mem_wdata,
                   {ea[31:2], 2'b00}, exp_wm, exp_wd);
        else pass_cnt++;
        if (c == 1) begin
          got_addr = mem_addr; got_wdata = mem_wdata; got_wmask = mem_wmask;
        end
        start = 1'($urandom);
        scramble_inputs();
        mem_ready = (c == lat);
        mem_rdata = (c == lat) ? rdata : $urandom;
        @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      start = 1'b0;
      total_cnt++;
      if (done !== 1'b1 || misaligned !== 1'b0 || illegal !== 1'b0 || bus_err !== 1'b0 ||
          mem_req !== 1'b0 || wb_en !== exp_wben ||
          wb_rd !== (exp_wben ? r : 5'd0) || wb_data !== (exp_wben ? exp_ld : 32'd0))
        $display("FAIL %s done: done=%b flags=%b%b%b req=%b wben=%b rd=%0d data=%h exp wben=%b rd=%0d data=%h",
                 tag, done, misaligned, illegal, bus_err, mem_req, wb_en, wb_rd, wb_data,
                 exp_wben, exp_wben ? r : 5'd0, exp_wben ? exp_ld : 32'd0);
      else pass_cnt++;
      got_wben = wb_en;
      got_wb = wb_data;
      @(posedge clk); #1;
      total_cnt++;
      if (done !== 1'b0 || busy !== 1'b0 || wb_en !== 1'b0)
        $display("FAIL %s idle_after: done=%b busy=%b wben=%b exp 0/0/0", tag, done, busy, wb_en);
      else pass_cnt++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #12;
    total_cnt++;
    if ({busy, done, misaligned, illegal, bus_err, mem_req, mem_we, mem_addr, mem_wdata,
         mem_wmask, wb_en, wb_rd, wb_data} !== '0)
      $display("FAIL reset_outputs: busy=%b done=%b req=%b addr=%h wben=%b exp all 0",
               busy, done, mem_req, mem_addr, wb_en);
    else pass_cnt++;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stores();
    logic [31:0] ad, wd, wb; logic [3:0] wm; logic we;
    run_txn(1'b1, 3'd2, 32'h100, 32'd4, 32'hDEADBEEF, 5'd7, 3, 32'h0, "sw", ad, wd, wm, we, wb);
    total_cnt++;
    if (ad !== 32'h104 || wm !== 4'b1111 || wd !== 32'hDEADBEEF || we !== 1'b0)
      $display("FAIL sw_fmt: addr=%h wm=%b wd=%h wben=%b exp 00000104 1111 deadbeef 0", ad, wm, wd, we);
    else pass_cnt++;
    run_txn(1'b1, 3'd0, 32'h100, 32'd3, 32'h000000A5, 5'd1, 1, 32'h0, "sb", ad, wd, wm, we, wb);
    total_cnt++;
    if (ad !== 32'h100 || wm !== 4'b1000 || wd !== 32'hA5A5A5A5)
      $display("FAIL sb_fmt: addr=%h wm=%b wd=%h exp 00000100 1000 a5a5a5a5", ad, wm, wd);
    else pass_cnt++;
    run_txn(1'b1, 3'd1, 32'h100, 32'd2, 32'h1234BEEF, 5'd1, 2, 32'h0, "sh", ad, wd, wm, we, wb);
    total_cnt++;
    if (wm !== 4'b1100 || wd !== 32'hBEEFBEEF)
      $display("FAIL sh_fmt: wm=%b wd=%h exp 1100 beefbeef", wm, wd);
    else pass_cnt++;
  endtask

  task automatic test_loads();
    logic [31:0] ad, wd, wb; logic [3:0] wm; logic we;
    logic [31:0] rdv;
    rdv = 32'h80F07F01;
    run_txn(1'b0, 3'd0, 32'h200, 32'd3, 32'h0, 5'd3, 1, rdv, "lb", ad, wd, wm, we, wb);
    total_cnt++;
    if (wb !== 32'hFFFFFF80) $display("FAIL lb_val: got %h exp ffffff80", wb); else pass_cnt++;
    run_txn(1'b0, 3'd4, 32'h200, 32'd3, 32'h0, 5'd3, 2, rdv, "lbu", ad, wd, wm, we, wb);
    total_cnt++;
    if (wb !== 32'h00000080) $display("FAIL lbu_val: got %h exp 00000080", wb); else pass_cnt++;
    run_txn(1'b0, 3'd1, 32'h200, 32'd0, 32'h0, 5'd3, 1, rdv, "lh", ad, wd, wm, we, wb);
    total_cnt++;
    if (wb !== 32'h00007F01) $display("FAIL lh_val: got %h exp 00007f01", wb); else pass_cnt++;
    run_txn(1'b0, 3'd5, 32'h200, 32'd2, 32'h0, 5'd3, 3, rdv, "lhu", ad, wd, wm, we, wb);
    total_cnt++;
    if (wb !== 32'h000080F0) $display("FAIL lhu_val: got %h exp 000080f0", wb); else pass_cnt++;
    run_txn(1'b0, 3'd2, 32'h1FC, 32'd4, 32'h0, 5'd5, 1, rdv, "lw", ad, wd, wm, we, wb);
    total_cnt++;
    if (we !== 1'b1 || wb !== 32'h80F07F01 || ad !== 32'h200)
      $display("FAIL lw_val: wben=%b data=%h addr=%h exp 1 80f07f01 00000200", we, wb, ad);
    else pass_cnt++;
    run_txn(1'b0, 3'd2, 32'h200, 32'd0, 32'h0, 5'd0, 2, rdv, "lw_x0", ad, wd, wm, we, wb);
    total_cnt++;
    if (we !== 1'b0) $display("FAIL lw_x0_wben: got %b exp 0", we); else pass_cnt++;
  endtask

  task automatic test_faults();
    logic [31:0] ad, wd, wb; logic [3:0] wm; logic we;
    run_txn(1'b0, 3'd2, 32'h200, 32'd2, 32'h0, 5'd4, 1, 32'h0, "lw_mis", ad, wd, wm, we, wb);
    run_txn(1'b0, 3'd3, 32'h200, 32'd0, 32'h0, 5'd4, 1, 32'h0, "ld_ill3", ad, wd, wm, we, wb);
    run_txn(1'b1, 3'd4, 32'h200, 32'd0, 32'h0, 5'd4, 1, 32'h0, "st_ill4", ad, wd, wm, we, wb);
    run_txn(1'b0, 3'd5, 32'h201, 32'd0, 32'h0, 5'd4, 1, 32'h0, "lhu_mis", ad, wd, wm, we, wb);
  endtask

  task automatic test_addr_wrap();
    logic [31:0] ad, wd, wb; logic [3:0] wm; logic we;
    run_txn(1'b0, 3'd2, 32'hFFFFFFFF, 32'd1, 32'h0, 5'd9, 1, 32'h13572468, "wrap", ad, wd, wm, we, wb);
    total_cnt++;
    if (ad !== 32'h0 || wb !== 32'h13572468)
      $display("FAIL wrap_addr: addr=%h data=%h exp 00000000 13572468", ad, wb);
    else pass_cnt++;
  endtask

  task automatic test_watchdog();
    start = 1'b1; is_store = 1'b0; funct3 = 3'd2; rs1 = 32'h300; imm = 32'd0; rd = 5'd6;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      total_cnt++;
      if (mem_req !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || mem_addr !== 32'h300)
        $display("FAIL wdog_req_c%0d: req=%b done=%b busy=%b addr=%h exp 1 0 1 00000300",
                 c, mem_req, done, busy, mem_addr);
      else pass_cnt++;
      // start while busy must be ignored, including a legal aligned request
      start = 1'b1; is_store = 1'b1; funct3 = 3'd2; rs1 = 32'h400; imm = 32'd0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    total_cnt++;
    if (done !== 1'b1 || bus_err !== 1'b1 || illegal !== 1'b0 || misaligned !== 1'b0 ||
        mem_req !== 1'b0 || wb_en !== 1'b0)
      $display("FAIL wdog_done: done=%b berr=%b ill=%b mis=%b req=%b wben=%b exp 1 1 0 0 0 0",
               done, bus_err, illegal, misaligned, mem_req, wb_en);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0 || bus_err !== 1'b0)
      $display("FAIL wdog_after: done=%b busy=%b req=%b berr=%b exp 0 0 0 0",
               done, busy, mem_req, bus_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_req();
    logic [31:0] ad, wd, wb; logic [3:0] wm; logic we;
    start = 1'b1; is_store = 1'b0; funct3 = 3'd2; rs1 = 32'h500; imm = 32'd8; rd = 5'd2;
    @(posedge clk); #1;
    start = 1'b0;
    total_cnt++;
    if (mem_req !== 1'b1) $display("FAIL rstmid_pre: req=%b exp 1", mem_req); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rstmid_async: req=%b busy=%b done=%b exp 0 0 0", mem_req, busy, done);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rstmid_hold: req=%b busy=%b done=%b exp 0 0 0", mem_req, busy, done);
    else pass_cnt++;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b0, 3'd2, 32'h500, 32'd8, 32'h0, 5'd2, 2, 32'hCAFEF00D, "rst_lw", ad, wd, wm, we, wb);
    total_cnt++;
    if (wb !== 32'hCAFEF00D || ad !== 32'h508)
      $display("FAIL rst_lw_val: data=%h addr=%h exp cafef00d 00000508", wb, ad);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] ad, wd, wb; logic [3:0] wm; logic we;
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, 5'($urandom),
              int'($urandom_range(1, 4)), $urandom, "rand", ad, wd, wm, we, wb);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = '0;
    rs1 = '0; rs2 = '0; imm = '0; rd = '0; mem_ready = 1'b0; mem_rdata = '0;
    test_reset();
    test_stores();
    test_loads();
    test_faults();
    test_addr_wrap();
    test_watchdog();
    test_reset_mid_req();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
